// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one window per accepted pixel once the window is fully inside the image.
module window3x3_gen #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       out_valid,
    output logic [7:0] p0,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic       out_eof
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb0_rd, lb1_rd;
    logic          win_ok, last_px;

    // A start-of-frame pixel is (0,0) regardless of where the counters are.
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = cur_col;
        row_d   = cur_row;
        if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
            col_d = cur_col + CW'(1);
        end
        lb0_rd  = lb0[cur_col];
        lb1_rd  = lb1[cur_col];
        win_ok  = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
        last_px = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_valid) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line buffers are deliberately not reset; output gating hides stale rows.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[cur_col] <= lb1_rd;
            lb1[cur_col] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            p0 <= '0; p1 <= '0; p2 <= '0;
            p3 <= '0; p4 <= '0; p5 <= '0;
            p6 <= '0; p7 <= '0; p8 <= '0;
        end else begin
            out_valid <= in_valid && win_ok;
            out_eof   <= in_valid && last_px;
            if (in_valid) begin
                p0 <= p1; p1 <= p2; p2 <= lb0_rd;
                p3 <= p4; p4 <= p5; p5 <= lb1_rd;
                p6 <= p7; p7 <= p8; p8 <= in_data;
            end
        end
    end

endmodule
